// File: rtl/quad_pkg.sv
// Shared types and the quadrature transition decoder for quad_decoder_counter.
package quad_pkg;

    typedef logic [1:0] ab_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_ERR  = 2'd3
    } step_t;

    // {a,b} Gray sequence: up is 00->10->11->01->00, down is its reverse.
    function automatic step_t decode(ab_t prev, ab_t cur);
        step_t s;
        s = STEP_NONE;
        case ({prev, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_UP;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_DN;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: s = STEP_ERR;
            default:                                s = STEP_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/quad_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous encoder pin.
module quad_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sr <= '0;
        else       sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature encoder decoder (x4) with an N-bit position counter, clear/load,
// terminal ticks and a saturating illegal-transition counter.
module quad_decoder_counter
    import quad_pkg::*;
#(
    parameter int N           = 16,
    parameter int SYNC_STAGES = 2,
    parameter int WRAP        = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         syn_clr,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         dir,
    output logic         step_tick,
    output logic         err_tick,
    output logic [7:0]   err_cnt,
    output logic         max_tick,
    output logic         min_tick
);

    localparam logic [N-1:0] Q_MAX = {N{1'b1}};

    logic                   a_s, b_s;
    ab_t                    ab_s, prev_ab;
    logic                   primed;
    logic [SYNC_STAGES-1:0] fill_sr;
    logic                   sync_valid;
    step_t                  step;
    logic [N-1:0]           q_step;
    logic                   step_ok;

    quad_sync #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .reset(reset), .d(a_in), .q(a_s));
    quad_sync #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .reset(reset), .d(b_in), .q(b_s));

    assign ab_s = {a_s, b_s};

    // Priming waits until the synchronizers hold real pin samples rather than
    // their reset zeros, so a resting nonzero phase never decodes as motion.
    assign sync_valid = fill_sr[SYNC_STAGES-1];

    always_comb begin
        step = primed ? decode(prev_ab, ab_s) : STEP_NONE;
    end

    always_comb begin
        q_step  = q;
        step_ok = 1'b0;
        if (step == STEP_UP) begin
            if (q != Q_MAX || WRAP != 0) begin
                q_step  = q + 1'b1;
                step_ok = 1'b1;
            end
        end else if (step == STEP_DN) begin
            if (q != '0 || WRAP != 0) begin
                q_step  = q - 1'b1;
                step_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_sr   <= '0;
            prev_ab   <= 2'b00;
            primed    <= 1'b0;
            q         <= '0;
            dir       <= 1'b1;
            step_tick <= 1'b0;
            err_tick  <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            fill_sr   <= {fill_sr[SYNC_STAGES-2:0], 1'b1};
            prev_ab   <= ab_s;
            step_tick <= 1'b0;
            err_tick  <= 1'b0;
            if (sync_valid) primed <= 1'b1;

            if (step == STEP_ERR) begin
                err_tick <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            end

            // Direction follows every legal step, even when the count is preempted.
            if (step == STEP_UP)      dir <= 1'b1;
            else if (step == STEP_DN) dir <= 1'b0;

            if (syn_clr) begin
                q <= '0;
            end else if (load) begin
                q <= d;
            end else if (step_ok) begin
                q         <= q_step;
                step_tick <= 1'b1;
            end
        end
    end

    assign max_tick = (q == Q_MAX);
    assign min_tick = (q == '0);

endmodule
